// File: rtl/bank_rsp_return_buffer.sv
// Per-channel read-return FIFOs merged onto one output port by round-robin, with credit-return pulses.
// Optional BANK_RSP_BYPASS_EN: an incoming beat passes straight to out_* when the buffer is idle.
module bank_rsp_return_buffer #(
  parameter int CHANNEL_NUM = 3,
  parameter int ENTRY_NUM   = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNEL_NUM-1:0]           ch_rsp_valid,
  input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] ch_rsp_data,
  input  logic [CHANNEL_NUM*TAG_WIDTH-1:0] ch_rsp_tag,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [TAG_WIDTH-1:0]             out_tag,
  output logic [1:0]                       out_ch_id,
  output logic [CHANNEL_NUM-1:0]           channels_credit_release,
  output logic [CHANNEL_NUM-1:0]           ch_ovf_err
);
  localparam int CH_W  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int SUM_W = CH_W + 1;
  localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam int CNT_W = $clog2(ENTRY_NUM + 1);

  logic [CHANNEL_NUM-1:0] in_vld, nonempty, push, pop, byp_take, ovf_set;
  logic [DATA_WIDTH-1:0]  in_data   [CHANNEL_NUM];
  logic [TAG_WIDTH-1:0]   in_tag    [CHANNEL_NUM];
  logic [DATA_WIDTH-1:0]  head_data [CHANNEL_NUM];
  logic [TAG_WIDTH-1:0]   head_tag  [CHANNEL_NUM];

  logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   lock_q, lock_d;
  logic [CH_W-1:0]        lock_ch_q, lock_ch_d;
  logic [CHANNEL_NUM-1:0] rel_q, rel_d;
  logic [CHANNEL_NUM-1:0] ovf_q, ovf_d;

  logic [CHANNEL_NUM-1:0] rr_req;
  logic                   rr_found;
  logic [CH_W-1:0]        rr_ch;
  logic [SUM_W-1:0]       rr_sum;
  logic                   use_byp, sel_valid, handshake, rdy_eff;
  logic [CH_W-1:0]        gnt;
  logic [CHANNEL_NUM-1:0] gnt_oh;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [TAG_WIDTH-1:0]   sel_tag;

  assign in_vld  = rst ? '0 : ch_rsp_valid;
  assign rdy_eff = out_ready & ~rst;

  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem_data_q [ENTRY_NUM];
    logic [DATA_WIDTH-1:0] mem_data_d [ENTRY_NUM];
    logic [TAG_WIDTH-1:0]  mem_tag_q  [ENTRY_NUM];
    logic [TAG_WIDTH-1:0]  mem_tag_d  [ENTRY_NUM];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  full;

    assign in_data[c]   = ch_rsp_data[c*DATA_WIDTH +: DATA_WIDTH];
    assign in_tag[c]    = ch_rsp_tag[c*TAG_WIDTH +: TAG_WIDTH];
    assign full         = (cnt_q == CNT_W'(ENTRY_NUM));
    assign nonempty[c]  = (cnt_q != '0);
    assign head_data[c] = mem_data_q[rd_ptr_q];
    assign head_tag[c]  = mem_tag_q[rd_ptr_q];
    // A full FIFO still accepts a beat when its head leaves in the same cycle.
    assign push[c]      = in_vld[c] & ~byp_take[c] & (~full | pop[c]);
    assign ovf_set[c]   = in_vld[c] & ~byp_take[c] & full & ~pop[c];

    always_comb begin
      mem_data_d = mem_data_q;
      mem_tag_d  = mem_tag_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      if (push[c]) begin
        mem_data_d[wr_ptr_q] = in_data[c];
        mem_tag_d[wr_ptr_q]  = in_tag[c];
        wr_ptr_d = (wr_ptr_q == PTR_W'(ENTRY_NUM - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop[c]) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(ENTRY_NUM - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push[c], pop[c]})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      mem_data_q <= mem_data_d;
      mem_tag_q  <= mem_tag_d;
    end
  end

  always_comb begin
    use_byp = 1'b0;
    rr_req  = nonempty;
`ifdef BANK_RSP_BYPASS_EN
    if (!lock_q && (nonempty == '0)) begin
      use_byp = 1'b1;
      rr_req  = in_vld;
    end
`endif
    rr_found = 1'b0;
    rr_ch    = '0;
    rr_sum   = '0;
    // Descending scan so the lowest offset from rr_ptr wins.
    for (int i = CHANNEL_NUM - 1; i >= 0; i--) begin
      rr_sum = {1'b0, rr_ptr_q} + SUM_W'(i);
      if (rr_sum >= SUM_W'(CHANNEL_NUM)) rr_sum = rr_sum - SUM_W'(CHANNEL_NUM);
      if (rr_req[rr_sum[CH_W-1:0]]) begin
        rr_found = 1'b1;
        rr_ch    = rr_sum[CH_W-1:0];
      end
    end
  end

  always_comb begin
    gnt       = lock_q ? lock_ch_q : rr_ch;
    sel_valid = lock_q | rr_found;
    gnt_oh    = CHANNEL_NUM'(1) << gnt;
    sel_data  = use_byp ? in_data[gnt] : head_data[gnt];
    sel_tag   = use_byp ? in_tag[gnt]  : head_tag[gnt];
    handshake = sel_valid & rdy_eff;
    pop       = (handshake & ~use_byp) ? gnt_oh : '0;
    byp_take  = (handshake & use_byp)  ? gnt_oh : '0;
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    rel_d     = '0;
    ovf_d     = ovf_q | ovf_set;
    if (handshake) begin
      rr_ptr_d = (gnt == CH_W'(CHANNEL_NUM - 1)) ? '0 : gnt + 1'b1;
      lock_d   = 1'b0;
      rel_d    = gnt_oh;
    end else if (sel_valid) begin
      lock_d    = 1'b1;
      lock_ch_d = gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      rel_q     <= '0;
      ovf_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      rel_q     <= rel_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid               = sel_valid;
  assign out_data                = sel_valid ? sel_data : '0;
  assign out_tag                 = sel_valid ? sel_tag : '0;
  assign out_ch_id               = sel_valid ? 2'(gnt) : 2'd0;
  assign channels_credit_release = rel_q;
  assign ch_ovf_err              = ovf_q;
endmodule

// File: tb/tb_bank_rsp_return_buffer.sv
// Randomized bench for bank_rsp_return_buffer against a queue-based reference model.
module tb_bank_rsp_return_buffer;
  localparam int CH = 3, E = 8, DW = 64, TW = 8;
  localparam int VW = 1 + 2 + TW + DW + CH + CH;
`ifdef BANK_RSP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed { logic [TW-1:0] t; logic [DW-1:0] d; } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0]    ch_rsp_valid = '0;
  logic [CH*DW-1:0] ch_rsp_data = '0;
  logic [CH*TW-1:0] ch_rsp_tag = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [TW-1:0]    out_tag;
  logic [1:0]       out_ch_id;
  logic [CH-1:0]    channels_credit_release;
  logic [CH-1:0]    ch_ovf_err;

  bank_rsp_return_buffer #(.CHANNEL_NUM(CH), .ENTRY_NUM(E), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .ch_rsp_valid(ch_rsp_valid), .ch_rsp_data(ch_rsp_data), .ch_rsp_tag(ch_rsp_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_ch_id(out_ch_id), .channels_credit_release(channels_credit_release), .ch_ovf_err(ch_ovf_err)
  );

  always #5 clk = ~clk;

  beat_t         mq [CH][$];
  int            m_rr = 0;
  bit            m_lock = 1'b0;
  int            m_lock_ch = 0;
  logic [CH-1:0] m_rel = '0, m_ovf = '0;

  logic          exp_valid;
  int            exp_ch;
  bit            exp_byp;
  logic [DW-1:0] exp_d;
  logic [TW-1:0] exp_t;
  logic [VW-1:0] exp_vec;
  wire  [VW-1:0] obs_vec = {out_valid, out_ch_id, out_tag, out_data, channels_credit_release, ch_ovf_err};

  int n_cmp = 0, n_bad = 0;

  // Expected outputs for the current cycle: locked grant, else first non-empty queue from rr.
  function automatic void predict();
    int c;
    exp_valid = 1'b0; exp_ch = 0; exp_byp = 1'b0; exp_d = '0; exp_t = '0;
    if (m_lock) begin
      exp_valid = 1'b1; exp_ch = m_lock_ch;
    end else begin
      for (int i = 0; i < CH; i++) begin
        c = (m_rr + i) % CH;
        if (!exp_valid && mq[c].size() > 0) begin exp_valid = 1'b1; exp_ch = c; end
      end
      if (!exp_valid && BYP && !rst) begin
        for (int i = 0; i < CH; i++) begin
          c = (m_rr + i) % CH;
          if (!exp_valid && ch_rsp_valid[c]) begin exp_valid = 1'b1; exp_byp = 1'b1; exp_ch = c; end
        end
      end
    end
    if (exp_valid) begin
      if (exp_byp) begin
        exp_d = ch_rsp_data[exp_ch*DW +: DW];
        exp_t = ch_rsp_tag[exp_ch*TW +: TW];
      end else begin
        exp_d = mq[exp_ch][0].d;
        exp_t = mq[exp_ch][0].t;
      end
    end
    exp_vec = {exp_valid, 2'(exp_ch), exp_t, exp_d, m_rel, m_ovf};
  endfunction

  function automatic void update();
    bit hs;
    if (rst) begin
      for (int c = 0; c < CH; c++) mq[c].delete();
      m_rr = 0; m_lock = 1'b0; m_lock_ch = 0; m_rel = '0; m_ovf = '0;
    end else begin
      hs = exp_valid && out_ready;
      m_rel = '0;
      if (hs) begin
        if (!exp_byp) void'(mq[exp_ch].pop_front());
        m_rr = (exp_ch + 1) % CH;
        m_rel[exp_ch] = 1'b1;
        m_lock = 1'b0;
      end else if (exp_valid) begin
        m_lock = 1'b1; m_lock_ch = exp_ch;
      end
      for (int c = 0; c < CH; c++) begin
        if (ch_rsp_valid[c] && !(hs && exp_byp && exp_ch == c)) begin
          if (mq[c].size() < E) mq[c].push_back({ch_rsp_tag[c*TW +: TW], ch_rsp_data[c*DW +: DW]});
          else m_ovf[c] = 1'b1;
        end
      end
    end
  endfunction

  task automatic drive(input logic r, input logic [CH-1:0] v, input logic rdy, input bit fix, input logic [TW-1:0] tg);
    @(negedge clk);
    rst = r; ch_rsp_valid = v; out_ready = rdy;
    for (int c = 0; c < CH; c++) begin
      ch_rsp_data[c*DW +: DW] = {$urandom(), $urandom()};
      ch_rsp_tag[c*TW +: TW]  = fix ? tg : TW'($urandom());
    end
    #1;
    predict();
  endtask

  task automatic step();
    update();
    @(posedge clk);
  endtask

  task automatic apply_reset();
    drive(1'b1, CH'($urandom()), 1'($urandom()), 1'b0, '0);
    step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) apply_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    n_cmp++;
    if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL reset_model: got %h want %h", obs_vec, exp_vec); end
    n_cmp++;
    if ({out_valid, channels_credit_release, ch_ovf_err} !== 7'b0)
      begin n_bad++; $display("FAIL reset_state: got %b want 0", {out_valid, channels_credit_release, ch_ovf_err}); end
    step();
  endtask

  task automatic test_single();
    apply_reset();
    drive(1'b0, 3'b001, 1'b1, 1'b1, 8'h05);
    n_cmp++;
    if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL single_c0: got %h want %h", obs_vec, exp_vec); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_latency: got %b want 0", out_valid); end
    step();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    n_cmp++;
    if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL single_c1: got %h want %h", obs_vec, exp_vec); end
    n_cmp++;
    if ({out_valid, out_tag, out_ch_id} !== {1'b1, 8'h05, 2'd0})
      begin n_bad++; $display("FAIL single_out: got %h want %h", {out_valid, out_tag, out_ch_id}, {1'b1, 8'h05, 2'd0}); end
    step();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    n_cmp++;
    if ({out_valid, channels_credit_release} !== 4'b0001)
      begin n_bad++; $display("FAIL single_release: got %b want 0001", {out_valid, channels_credit_release}); end
    step();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    n_cmp++;
    if (channels_credit_release !== 3'b000) begin n_bad++; $display("FAIL single_pulse_width: got %b want 000", channels_credit_release); end
    step();
  endtask

  task automatic test_bypass();
    apply_reset();
    drive(1'b0, 3'b010, 1'b1, 1'b1, 8'h3A);
    n_cmp++;
    if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL bypass_c0: got %h want %h", obs_vec, exp_vec); end
    n_cmp++;
    if ({out_valid, out_tag, out_ch_id} !== {1'b1, 8'h3A, 2'd1})
      begin n_bad++; $display("FAIL bypass_out: got %h want %h", {out_valid, out_tag, out_ch_id}, {1'b1, 8'h3A, 2'd1}); end
    step();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    n_cmp++;
    if ({out_valid, channels_credit_release} !== 4'b0010)
      begin n_bad++; $display("FAIL bypass_release: got %b want 0010", {out_valid, channels_credit_release}); end
    step();
  endtask

  task automatic test_three_way();
    logic [17:0] rel_seq = '0;
    logic [5:0]  id_seq = '0;
    int          n_hs = 0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, (i == 0) ? 3'b111 : 3'b000, 1'b1, 1'b0, '0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL three_way_c%0d: got %h want %h", i, obs_vec, exp_vec); end
      if (out_valid === 1'b1) begin id_seq = {id_seq[3:0], out_ch_id}; n_hs++; end
      rel_seq = {rel_seq[14:0], channels_credit_release};
      step();
    end
    n_cmp++;
    if (n_hs != 3 || id_seq !== 6'b00_01_10) begin n_bad++; $display("FAIL three_way_ids: got %0d/%b want 3/000110", n_hs, id_seq); end
    n_cmp++;
    if (rel_seq !== (BYP ? 18'b000_001_010_100_000_000 : 18'b000_000_001_010_100_000))
      begin n_bad++; $display("FAIL three_way_release: got %b", rel_seq); end
  endtask

  task automatic test_lock();
    logic [DW-1:0] held;
    apply_reset();
    drive(1'b0, 3'b010, 1'b0, 1'b0, '0);
    n_cmp++;
    if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL lock_c0: got %h want %h", obs_vec, exp_vec); end
    step();
    drive(1'b0, 3'b001, 1'b0, 1'b0, '0);
    held = exp_d;
    n_cmp++;
    if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL lock_c1: got %h want %h", obs_vec, exp_vec); end
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      n_cmp++;
      if ({out_valid, out_ch_id, out_data} !== {1'b1, 2'd1, held})
        begin n_bad++; $display("FAIL lock_hold%0d: got %0d %h want 1 %h", i, out_ch_id, out_data, held); end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL lock_drain%0d: got %h want %h", i, obs_vec, exp_vec); end
      if (i == 1) begin
        n_cmp++;
        if (out_ch_id !== 2'd0) begin n_bad++; $display("FAIL lock_next: got %0d want 0", out_ch_id); end
      end
      step();
    end
  endtask

  task automatic test_overflow();
    int n_out;
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset();
      for (int i = 0; i < ((pass == 0) ? 9 : 8); i++) begin
        drive(1'b0, 3'b100, 1'b0, 1'b0, '0);
        n_cmp++;
        if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL ovf%0d_fill%0d: got %h want %h", pass, i, obs_vec, exp_vec); end
        step();
      end
      if (pass == 1) begin
        drive(1'b0, 3'b100, 1'b1, 1'b0, '0);
        n_cmp++;
        if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL ovf_pop_push: got %h want %h", obs_vec, exp_vec); end
        step();
      end
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      n_cmp++;
      if (ch_ovf_err !== ((pass == 0) ? 3'b100 : 3'b000))
        begin n_bad++; $display("FAIL ovf%0d_flag: got %b want %b", pass, ch_ovf_err, (pass == 0) ? 3'b100 : 3'b000); end
      step();
      n_out = 0;
      for (int i = 0; i < 12; i++) begin
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        n_cmp++;
        if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL ovf%0d_drain%0d: got %h want %h", pass, i, obs_vec, exp_vec); end
        if (out_valid === 1'b1) n_out++;
        step();
      end
      n_cmp++;
      if (n_out != 8) begin n_bad++; $display("FAIL ovf%0d_occupancy: got %0d want 8", pass, n_out); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1'b0, 3'b111, 1'b0, 1'b0, '0); step();
    drive(1'b0, 3'b001, 1'b0, 1'b0, '0); step();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    n_cmp++;
    if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL reset_mid_pre: got %h want %h", obs_vec, exp_vec); end
    step();
    drive(1'b1, CH'($urandom()), 1'b1, 1'b0, '0); step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      n_cmp++;
      if ({out_valid, channels_credit_release, ch_ovf_err} !== 7'b0)
        begin n_bad++; $display("FAIL reset_mid%0d: got %b want 0", i, {out_valid, channels_credit_release, ch_ovf_err}); end
      step();
    end
  endtask

  task automatic test_random();
    logic r, rdy;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      rdy = ((i / 60) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      drive(r, CH'($urandom()), rdy, 1'b0, '0);
      if (!r) begin
        n_cmp++;
        if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL random_c%0d: got %h want %h", i, obs_vec, exp_vec); end
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef BANK_RSP_BYPASS_EN
    test_bypass();
`else
    test_single();
`endif
    test_three_way();
    test_lock();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bank_rsp_return_buffer.md
BANK_RSP_RETURN_BUFFER -- requirements
Module: bank_rsp_return_buffer

Interface
REQ-001 SHALL have parameter CHANNEL_NUM, default 3, number of read-return channels.
REQ-002 SHALL have parameter ENTRY_NUM, default 8, entries per channel FIFO; equals the per-channel credit count at reset.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, response payload width.
REQ-004 SHALL have parameter TAG_WIDTH, default 8, issue-queue entry tag width.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port ch_rsp_valid, input, CHANNEL_NUM, per-channel response beat valid; no ready, credit-guaranteed.
REQ-008 SHALL have port ch_rsp_data, input, CHANNEL_NUM*DATA_WIDTH, packed payloads; channel c at [c*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port ch_rsp_tag, input, CHANNEL_NUM*TAG_WIDTH, packed tags, same packing.
REQ-010 SHALL have port out_valid, output, 1, response available downstream.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts.
REQ-012 SHALL have port out_data, output, DATA_WIDTH, selected payload.
REQ-013 SHALL have port out_tag, output, TAG_WIDTH, selected tag.
REQ-014 SHALL have port out_ch_id, output, 2, source channel of the selected beat.
REQ-015 SHALL have port channels_credit_release, output, CHANNEL_NUM, one-cycle credit-return pulse per channel to the credit manager.
REQ-016 SHALL have port ch_ovf_err, output, CHANNEL_NUM, sticky overflow flag per channel.

Function
REQ-017 SHALL hold one FIFO per channel, ENTRY_NUM deep, with wrapping read/write pointers and a 0..ENTRY_NUM occupancy counter.
REQ-018 SHALL write ch_rsp_data/tag into channel c's FIFO in any cycle ch_rsp_valid[c] is high and that FIFO is not full; all channels may write in the same cycle.
REQ-019 SHALL drop a beat arriving at a full FIFO, leave FIFO state unchanged, and set ch_rsp_valid-indexed ch_ovf_err[c] until reset.
REQ-020 SHALL allow simultaneous write and read on a full FIFO only when the read frees the slot in that cycle; that write is then accepted, not an overflow.
REQ-021 SHALL drive out_valid high when any FIFO is non-empty, with a registered-FIFO latency of one cycle from write to visibility.
REQ-022 SHALL select among non-empty FIFOs by round robin: search starts at rr_ptr, ascending, wrapping at CHANNEL_NUM.
REQ-023 SHALL set rr_ptr to (granted channel + 1) mod CHANNEL_NUM on each handshake (out_valid & out_ready); otherwise hold.
REQ-024 SHALL lock the grant while out_valid & ~out_ready: out_ch_id, out_data, out_tag stable until handshake, regardless of other channels filling.
REQ-025 SHALL pop the granted FIFO head on handshake; at most one pop per cycle.
REQ-026 SHALL pulse channels_credit_release[c] for exactly one cycle, the cycle after each handshake of a channel-c beat; back-to-back handshakes yield back-to-back pulses.
REQ-027 SHALL hold out_data/out_tag/out_ch_id at zero when out_valid is low.

Reset
REQ-028 SHALL, on rst high at a rising edge, clear all pointers, occupancy counters, rr_ptr (to 0), grant lock, channels_credit_release, and ch_ovf_err; out_valid low the following cycle.
REQ-029 SHALL discard all buffered beats on reset mid-operation and issue no credit release for them; credit manager reset restores credits.
REQ-030 SHALL ignore ch_rsp_valid and out_ready in any cycle rst is high.

Configuration
REQ-031 SHALL support macro BANK_RSP_BYPASS_EN.
REQ-032 SHALL, with BANK_RSP_BYPASS_EN defined, when all FIFOs are empty and no grant is locked, present the round-robin-selected incoming ch_rsp beat combinationally on out_* in the same cycle; if out_ready, that beat is not written, counts as a handshake (REQ-023, REQ-026); if not, it is written and locked as in REQ-024; other same-cycle beats are written normally.
REQ-033 SHALL, without BANK_RSP_BYPASS_EN, keep out_* driven only from FIFO heads (one-cycle latency, REQ-021).

Verification
REQ-034 SHALL verify: reset, ch_rsp_valid=001 tag 0x05, out_ready=1 -> out_valid next cycle, out_tag=0x05, out_ch_id=0, credit_release=001 one cycle later (bypass off).
REQ-035 SHALL verify: all three channels write one beat same cycle, out_ready=1 -> out_ch_id sequence 0,1,2, release pulses 001,010,100 on consecutive cycles.
REQ-036 SHALL verify: out_ready=0 with ch1 granted, then ch0 fills -> out_ch_id stays 1, data stable until out_ready=1.
REQ-037 SHALL verify: 9 writes to ch2 with out_ready=0 -> occupancy 8, ninth dropped, ch_ovf_err=100; write plus pop on full ch2 in same cycle -> no error.
REQ-038 SHALL verify: 4 beats buffered, rst pulsed -> out_valid=0, no credit_release pulses, ch_ovf_err=000.
REQ-039 SHALL verify, with BANK_RSP_BYPASS_EN: empty buffer, ch_rsp_valid=010 tag 0x3A, out_ready=1 -> same-cycle out_valid, out_tag=0x3A, occupancy stays 0, release=010 next cycle.
